// File: rtl/ninjakun_busarb.sv
// ninjakun_busarb: arbiter/sequencer for the shared video/PSG bus used by
// the main CPU (CP0) and the sub CPU (CP1). One access at a time is placed on
// SH_ADR/SH_SEL for the address decoder. SH_EN is held for ACC_CYC cycles,
// then the owner gets a one-cycle ACK. The other CPU is stalled via its WAIT.
//
// Ports:
//   MCLK, RESET             clock, asynchronous active-high reset
//   CPn_REQ/WR/AD/DO        request level, write flag, address, write data
//   CPn_DI                  latched read data for CPn
//   CPn_ACK                 one-cycle completion pulse
//   CPn_WAIT                stall (combinational: REQ and not ACK)
//   SH_EN/ADR/SEL/WE/DO     shared-bus strobe, address, owner, write enable, data
//   SH_DI                   shared-bus read data, sampled on the last access cycle
module ninjakun_busarb #(
  parameter int unsigned ACC_CYC = 2
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        CP0_REQ,
  input  logic        CP0_WR,
  input  logic [15:0] CP0_AD,
  input  logic [7:0]  CP0_DO,
  output logic [7:0]  CP0_DI,
  output logic        CP0_ACK,
  output logic        CP0_WAIT,
  input  logic        CP1_REQ,
  input  logic        CP1_WR,
  input  logic [15:0] CP1_AD,
  input  logic [7:0]  CP1_DO,
  output logic [7:0]  CP1_DI,
  output logic        CP1_ACK,
  output logic        CP1_WAIT,
  output logic        SH_EN,
  output logic [15:0] SH_ADR,
  output logic        SH_SEL,
  output logic        SH_WE,
  output logic [7:0]  SH_DO,
  input  logic [7:0]  SH_DI
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          rel0;
  logic          rel1;
  logic          elig0;
  logic          elig1;
  logic          gnt_any;
  logic          gnt_sel;

  // A requester whose access was already served must drop REQ before it is
  // eligible again, so a held REQ cannot trigger a duplicate access.
  assign elig0   = CP0_REQ & ~rel0;
  assign elig1   = CP1_REQ & ~rel1;
  assign gnt_any = elig0 | elig1;
  // On a tie the requester that did not win last time takes the bus.
  assign gnt_sel = (elig0 & elig1) ? ~last : elig1;

  // ACK is high exactly in the DONE cycle of its owner, so WAIT drops there.
  assign CP0_WAIT = CP0_REQ & ~CP0_ACK;
  assign CP1_WAIT = CP1_REQ & ~CP1_ACK;

  // Sequencer: grant in IDLE, hold the bus for ACC_CYC cycles, acknowledge.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      rel0    <= 1'b0;
      rel1    <= 1'b0;
      SH_EN   <= 1'b0;
      SH_WE   <= 1'b0;
      SH_ADR  <= '0;
      SH_SEL  <= 1'b0;
      SH_DO   <= '0;
      CP0_DI  <= '0;
      CP1_DI  <= '0;
      CP0_ACK <= 1'b0;
      CP1_ACK <= 1'b0;
    end else begin
      CP0_ACK <= 1'b0;
      CP1_ACK <= 1'b0;
      // Release flag: set when the owner still holds REQ in its DONE cycle,
      // cleared whenever REQ is seen low.
      rel0 <= CP0_REQ & (rel0 | (state == ST_DONE & ~SH_SEL));
      rel1 <= CP1_REQ & (rel1 | (state == ST_DONE & SH_SEL));

      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            SH_ADR <= gnt_sel ? CP1_AD : CP0_AD;
            SH_DO  <= gnt_sel ? CP1_DO : CP0_DO;
            SH_WE  <= gnt_sel ? CP1_WR : CP0_WR;
            SH_SEL <= gnt_sel;
            SH_EN  <= 1'b1;
            last   <= gnt_sel;
            cnt    <= CW'(ACC_CYC - 1);
            state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!SH_WE) begin
              if (SH_SEL) CP1_DI <= SH_DI;
              else        CP0_DI <= SH_DI;
            end
            SH_EN   <= 1'b0;
            SH_WE   <= 1'b0;
            CP0_ACK <= ~SH_SEL;
            CP1_ACK <= SH_SEL;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ninjakun_busarb.sv
// Self-checking bench for ninjakun_busarb. A transaction-timing reference
// model predicts every output each cycle from the grant time of the current
// access; directed sequences cover the listed scenarios, then randomized CPU
// agents exercise contention, held requests and data changes after grant.
module tb_ninjakun_busarb;

  localparam int unsigned ACC = 2;

  logic        clk;
  logic        rst;
  logic        req  [2];
  logic        wr   [2];
  logic [15:0] ad   [2];
  logic [7:0]  dout [2];
  logic [7:0]  di   [2];
  logic        ack  [2];
  logic        wt   [2];
  logic        sh_en;
  logic [15:0] sh_adr;
  logic        sh_sel;
  logic        sh_we;
  logic [7:0]  sh_do;
  logic [7:0]  sh_di;

  ninjakun_busarb #(.ACC_CYC(ACC)) u_dut (
    .MCLK    (clk),
    .RESET   (rst),
    .CP0_REQ (req[0]),
    .CP0_WR  (wr[0]),
    .CP0_AD  (ad[0]),
    .CP0_DO  (dout[0]),
    .CP0_DI  (di[0]),
    .CP0_ACK (ack[0]),
    .CP0_WAIT(wt[0]),
    .CP1_REQ (req[1]),
    .CP1_WR  (wr[1]),
    .CP1_AD  (ad[1]),
    .CP1_DO  (dout[1]),
    .CP1_DI  (di[1]),
    .CP1_ACK (ack[1]),
    .CP1_WAIT(wt[1]),
    .SH_EN   (sh_en),
    .SH_ADR  (sh_adr),
    .SH_SEL  (sh_sel),
    .SH_WE   (sh_we),
    .SH_DO   (sh_do),
    .SH_DI   (sh_di)
  );

  // Two extra builds with the shortest and longest access length.
  logic        x_req   [2];
  logic [7:0]  x_di0   [2];
  logic [7:0]  x_di1   [2];
  logic        x_ack0  [2];
  logic        x_ack1  [2];
  logic        x_wait0 [2];
  logic        x_wait1 [2];
  logic        x_en    [2];
  logic [15:0] x_adr   [2];
  logic        x_sel   [2];
  logic        x_we    [2];
  logic [7:0]  x_do    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_alt
    ninjakun_busarb #(.ACC_CYC(gi == 0 ? 32'd1 : 32'd7)) u_alt (
      .MCLK    (clk),
      .RESET   (rst),
      .CP0_REQ (x_req[gi]),
      .CP0_WR  (1'b0),
      .CP0_AD  (16'h1234),
      .CP0_DO  (8'h00),
      .CP0_DI  (x_di0[gi]),
      .CP0_ACK (x_ack0[gi]),
      .CP0_WAIT(x_wait0[gi]),
      .CP1_REQ (1'b0),
      .CP1_WR  (1'b0),
      .CP1_AD  (16'h0000),
      .CP1_DO  (8'h00),
      .CP1_DI  (x_di1[gi]),
      .CP1_ACK (x_ack1[gi]),
      .CP1_WAIT(x_wait1[gi]),
      .SH_EN   (x_en[gi]),
      .SH_ADR  (x_adr[gi]),
      .SH_SEL  (x_sel[gi]),
      .SH_WE   (x_we[gi]),
      .SH_DO   (x_do[gi]),
      .SH_DI   (8'hA5)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: an access granted at edge m_g occupies the bus after
  // edges m_g .. m_g+ACC-1, acknowledges after edge m_g+ACC, and the arbiter
  // can grant again at edge m_g+ACC+2.
  int unsigned cyc;
  bit          m_active;
  int unsigned m_g;
  bit          m_owner;
  bit          m_we;
  logic [15:0] m_adr;
  logic [7:0]  m_do;
  bit          m_last;
  bit          m_rel [2];
  logic [7:0]  m_di  [2];
  bit          e_en;
  bit          e_we;
  bit          e_ack [2];

  function automatic void calc_exp();
    int unsigned k;
    k = cyc - m_g;
    e_en = m_active && (k < ACC);
    e_we = e_en && m_we;
    for (int n = 0; n < 2; n++) e_ack[n] = m_active && (k == ACC) && (m_owner == 1'(n));
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_g      = 0;
    m_owner  = 1'b0;
    m_we     = 1'b0;
    m_adr    = '0;
    m_do     = '0;
    m_last   = 1'b1;
    for (int n = 0; n < 2; n++) begin
      m_rel[n] = 1'b0;
      m_di[n]  = '0;
    end
    calc_exp();
  endfunction

  function automatic void model_edge();
    int unsigned k;
    bit busy;
    bit el [2];
    bit win;
    k    = cyc - m_g;
    busy = m_active && (k < ACC + 2);
    if (m_active && k == ACC && !m_we) m_di[m_owner] = sh_di;
    for (int n = 0; n < 2; n++) el[n] = req[n] && !m_rel[n];
    if (m_active && k == ACC + 1 && req[m_owner]) m_rel[m_owner] = 1'b1;
    for (int n = 0; n < 2; n++) if (!req[n]) m_rel[n] = 1'b0;
    if (!busy && (el[0] || el[1])) begin
      win      = (el[0] && el[1]) ? !m_last : el[1];
      m_owner  = win;
      m_adr    = ad[win];
      m_do     = dout[win];
      m_we     = wr[win];
      m_last   = win;
      m_active = 1'b1;
      m_g      = cyc;
    end
    calc_exp();
  endfunction

  task automatic compare();
    check("sh_en", 32'(sh_en), 32'(e_en));
    check("sh_we", 32'(sh_we), 32'(e_we));
    check("sh_adr", 32'(sh_adr), 32'(m_adr));
    check("sh_sel", 32'(sh_sel), 32'(m_owner));
    check("sh_do", 32'(sh_do), 32'(m_do));
    for (int n = 0; n < 2; n++) begin
      check($sformatf("ack%0d", n), 32'(ack[n]), 32'(e_ack[n]));
      check($sformatf("di%0d", n), 32'(di[n]), 32'(m_di[n]));
      check($sformatf("wait%0d", n), 32'(wt[n]), 32'(req[n] && !e_ack[n]));
    end
  endtask

  bit prev_en;
  bit grants [$];
  int en_cycles;
  int we_cycles;

  // One clock: model update at the edge, compare 1 time unit later,
  // return at the falling edge where inputs may change.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare();
    if (sh_en && !prev_en) grants.push_back(sh_sel);
    if (sh_en) en_cycles++;
    if (sh_we) we_cycles++;
    prev_en = sh_en;
    @(negedge clk);
  endtask

  task automatic run_until_ack(input int n, output int edges);
    edges = 0;
    for (int i = 1; i <= 40 && edges == 0; i++) begin
      step();
      if (ack[n]) edges = i;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    prev_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  int e;
  int base;
  int alt_en  [2];
  int alt_lat [2];
  int hold    [2];
  bit acked   [2];

  initial begin
    rst   = 1'b1;
    sh_di = '0;
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0; wr[n] = 1'b0; ad[n] = '0; dout[n] = '0;
      x_req[n] = 1'b0; alt_en[n] = 0; alt_lat[n] = 0; hold[n] = 0; acked[n] = 1'b0;
    end
    cyc = 0; prev_en = 1'b0; en_cycles = 0; we_cycles = 0;
    model_reset();
    repeat (2) step();
    rst = 1'b0;

    // Shortest and longest builds: strobe width and ACK latency.
    x_req[0] = 1'b1;
    x_req[1] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (x_en[i]) alt_en[i]++;
        if (x_ack0[i] && alt_lat[i] == 0) begin
          alt_lat[i] = c + 1;
          x_req[i]   = 1'b0;
        end
      end
    end
    check("acc1_en_width", 32'(alt_en[0]), 32'd1);
    check("acc7_en_width", 32'(alt_en[1]), 32'd7);
    check("acc1_ack_lat", 32'(alt_lat[0]), 32'd3);
    check("acc7_ack_lat", 32'(alt_lat[1]), 32'd9);
    check("acc1_di", 32'(x_di0[0]), 32'hA5);
    check("acc7_di", 32'(x_di0[1]), 32'hA5);

    // Single read by CPU0.
    req[0] = 1'b1; wr[0] = 1'b0; ad[0] = 16'hC123; sh_di = 8'h5A;
    base = en_cycles;
    run_until_ack(0, e);
    req[0] = 1'b0;
    check("rd_ack_lat", 32'(e + 1), 32'(ACC + 2));
    check("rd_en_width", 32'(en_cycles - base), 32'(ACC));
    check("rd_adr", 32'(sh_adr), 32'hC123);
    check("rd_sel", 32'(sh_sel), 32'd0);
    check("rd_di", 32'(di[0]), 32'h5A);
    step();

    // Single write by CPU1.
    req[1] = 1'b1; wr[1] = 1'b1; ad[1] = 16'hD805; dout[1] = 8'h3C; sh_di = 8'hE7;
    base = we_cycles;
    run_until_ack(1, e);
    req[1] = 1'b0; wr[1] = 1'b0;
    check("wr_ack_lat", 32'(e + 1), 32'(ACC + 2));
    check("wr_we_width", 32'(we_cycles - base), 32'(ACC));
    check("wr_do", 32'(sh_do), 32'h3C);
    check("wr_sel", 32'(sh_sel), 32'd1);
    check("wr_di_kept", 32'(di[1]), 32'h00);
    step();
    check("wr_ack_single", 32'(ack[1]), 32'd0);

    // REQ dropped right after grant: the access still completes.
    req[0] = 1'b1; ad[0] = 16'h0042; sh_di = 8'h99;
    step();
    req[0] = 1'b0;
    run_until_ack(0, e);
    check("drop_ack_lat", 32'(e), 32'(ACC));
    check("drop_di", 32'(di[0]), 32'h99);
    step();

    // Held REQ: no second access until REQ goes low and back high.
    req[0] = 1'b1; ad[0] = 16'h1111;
    run_until_ack(0, e);
    base = grants.size();
    repeat (10) step();
    check("held_no_reaccess", 32'(grants.size() - base), 32'd0);
    req[0] = 1'b0;
    step();
    req[0] = 1'b1;
    run_until_ack(0, e);
    req[0] = 1'b0;
    check("held_reaccess", 32'(grants.size() - base), 32'd1);
    check("held_reaccess_lat", 32'(e + 1), 32'(ACC + 2));
    step();

    // Reset during the first access cycle of a write.
    req[1] = 1'b1; wr[1] = 1'b1; ad[1] = 16'hD000; dout[1] = 8'h77;
    step();
    rst = 1'b1;
    #1;
    check("rst_en_async", 32'(sh_en), 32'd0);
    check("rst_we_async", 32'(sh_we), 32'd0);
    model_reset();
    prev_en = 1'b0;
    req[1] = 1'b0; wr[1] = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rst_no_ack", 32'(ack[1]), 32'd0);
    req[0] = 1'b1; wr[0] = 1'b0; ad[0] = 16'hC800; sh_di = 8'h3E;
    run_until_ack(0, e);
    req[0] = 1'b0;
    check("rst_fresh_lat", 32'(e + 1), 32'(ACC + 2));
    check("rst_fresh_di", 32'(di[0]), 32'h3E);
    step();

    // Round robin: two simultaneous pairs after reset, then both continuous.
    do_reset();
    grants.delete();
    for (int p = 0; p < 2; p++) begin
      req[0] = 1'b1; req[1] = 1'b1; wr[0] = 1'b0; wr[1] = 1'b0;
      for (int i = 0; i < 30 && (req[0] || req[1]); i++) begin
        step();
        for (int n = 0; n < 2; n++) if (ack[n]) req[n] = 1'b0;
      end
      step();
    end
    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < 2; n++) req[n] = !ack[n];
      step();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (2) step();
    check("rr_grants", 32'(grants.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) check($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(i % 2));

    // Randomized traffic: agents hold REQ 0..3 cycles past ACK, and
    // address/data/direction change every cycle regardless of grant.
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (req[n] && e_ack[n]) begin
          hold[n]  = int'($urandom_range(0, 3));
          acked[n] = 1'b1;
        end
        if (req[n] && acked[n]) begin
          if (hold[n] == 0) begin
            req[n]   = 1'b0;
            acked[n] = 1'b0;
          end else begin
            hold[n]--;
          end
        end else if (!req[n] && $urandom_range(0, 2) == 0) begin
          req[n] = 1'b1;
        end
        wr[n]   = 1'($urandom);
        ad[n]   = 16'($urandom);
        dout[n] = 8'($urandom);
      end
      sh_di = 8'($urandom);
      step();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ninjakun_busarb.md
Name: ninjakun_busarb

Overview:
- Arbiter/sequencer for the shared video/PSG bus used by the main CPU (CPU0) and sub CPU (CPU1).
- Serialises requests onto one shared bus (SH_ADR/SH_SEL), which feeds the existing address decoder (CPADR/CPSEL) and the shared RAMs/PSG behind it.
- Stalls the losing CPU with a wait signal and returns read data latched per requester.

Parameters:
- ACC_CYC, 2: number of cycles the shared bus is held per access (range 1..7).

Ports:
- MCLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CP0_REQ  in  1  CPU0 bus request; level, held until CP0_ACK.
- CP0_WR  in  1  CPU0 write (1) / read (0); valid with CP0_REQ.
- CP0_AD  in  16  CPU0 address.
- CP0_DO  in  8  CPU0 write data.
- CP0_DI  out  8  CPU0 read data, latched.
- CP0_ACK  out  1  one-cycle completion pulse to CPU0.
- CP0_WAIT  out  1  stall to CPU0.
- CP1_REQ, CP1_WR, CP1_AD, CP1_DO, CP1_DI, CP1_ACK, CP1_WAIT: same as the CP0 ports, for CPU1.
- SH_EN  out  1  shared-bus access strobe.
- SH_ADR  out  16  shared-bus address (to decoder CPADR).
- SH_SEL  out  1  owner of the access, 0 = CPU0, 1 = CPU1 (to decoder CPSEL).
- SH_WE  out  1  shared-bus write enable.
- SH_DO  out  8  shared-bus write data.
- SH_DI  in  8  shared-bus read data; valid while SH_EN is high.

Behaviour:
- Reset values (applied asynchronously):
  - state IDLE; SH_EN=0, SH_WE=0, SH_ADR=0, SH_SEL=0, SH_DO=0.
  - CP0_DI=CP1_DI=0; both ACKs 0.
  - LAST=1, so CPU0 wins the first tie.
  - Release flags cleared.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Eligible requester n: CPn_REQ=1 and its release flag is clear.
  - If none is eligible, stay in IDLE.
  - Exactly one eligible: grant it.
  - Both eligible: grant the one not equal to LAST (round-robin).
  - On grant: register SH_ADR<=CPn_AD, SH_SEL<=n, SH_DO<=CPn_DO, SH_WE<=CPn_WR; set LAST<=n; load counter with ACC_CYC-1; go to ACCESS.
- ACCESS:
  - SH_EN=1 throughout; SH_ADR, SH_SEL, SH_DO and SH_WE stable for exactly ACC_CYC cycles.
  - Counter decrements each cycle.
  - On the cycle where counter==0: if read, latch SH_DI into CPn_DI of the owner; go to DONE.
  - A write never modifies CPn_DI.
- DONE (one cycle):
  - SH_EN=0 and SH_WE=0; CPn_ACK=1 for the owner only.
  - Set the owner's release flag; go to IDLE.
- Release flag n: cleared on the first cycle CPn_REQ is sampled 0. This prevents a held REQ from causing a duplicate access. Requesters drop REQ after ACK.
- CPn_WAIT: combinational, equal to CPn_REQ AND NOT (state==DONE AND owner==n). WAIT is low in the ACK cycle.
- Latency:
  - REQ rises while IDLE with no contention: ACK in cycle ACC_CYC+2 after REQ is sampled (IDLE sample, ACC_CYC access cycles, then DONE).
  - Contended requester waits one full extra transaction (ACC_CYC+2 cycles) plus the IDLE cycle.
- A request arriving during ACCESS or DONE is held; it is arbitrated at the next IDLE.
- Request inputs are sampled only in IDLE. Changes to CPn_AD/CPn_DO/CPn_WR after the grant are ignored.
- CPn_REQ dropping mid-ACCESS (protocol violation): the access completes; ACK is still pulsed.
- RESET mid-ACCESS: SH_WE and SH_EN drop immediately (asynchronously); no ACK; the in-flight access is abandoned.
- No combinational path from SH_DI to any output.

Test Plan:
- Single read: CP0_REQ=1, CP0_WR=0, CP0_AD=0xC123, SH_DI=0x5A, ACC_CYC=2 -> SH_EN high 2 cycles with SH_ADR=0xC123 and SH_SEL=0; CP0_ACK pulses 4 cycles after sampling; CP0_DI=0x5A; CP0_WAIT high until the ACK cycle.
- Single write: CP1 writes 0x3C to 0xD805 -> SH_SEL=1, SH_WE=1 for exactly 2 cycles, SH_DO=0x3C; CP1_DI unchanged; CP1_ACK one pulse.
- Simultaneous requests after reset: CP0 and CP1 assert together -> CPU0 served first, then CPU1; a second simultaneous pair -> CPU0 first again (LAST=1 after CPU1); with CPU0 held continuously requesting, grants alternate 0,1,0,1.
- Held REQ: CP0_REQ kept high 10 cycles after ACK -> no second SH_EN until CP0_REQ goes low and back high.
- Reset mid-write: assert RESET during the first ACCESS cycle -> SH_WE=0 and SH_EN=0 in the same cycle; no ACK; after release, a fresh request completes normally.
- ACC_CYC=1 and ACC_CYC=7 builds: SH_EN width of 1 and 7 cycles respectively; ACK latency 3 and 9 cycles respectively.
